dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port synchronous data memory (16384 x 32b, 1-cycle read latency) between the CPU load/store unit (port 0) and the UART program-loader/DMA engine (port 1). Port 0 has fixed priority, and a starvation counter guarantees port 1 a grant within a bounded wait. Read responses are routed back to the issuing port one cycle after acceptance. The block sits between the CPU memory stage, the loader and the DMEM instance.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_starve_counter.sv | 48 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants for the data-memory arbiter
// Purpose: port index constants, default widths and a byte-enable width helper.
// Ports: none (package).
package dmem_arb_pkg;

  localparam int PORT_CPU         = 0;
  localparam int PORT_LOADER      = 1;

  localparam int ADDR_WIDTH_DEF   = 14;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int WAIT_MAX_DEF     = 4;
  localparam int WAIT_CNT_WIDTH   = 4;

  // One write-enable bit per data byte.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BE_WIDTH_DEF     = be_width(DATA_WIDTH_DEF);

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_starve_counter.sv
// rtl/dmem_arbiter_starve_counter.sv - saturating wait counter for the loader port
// Purpose: counts cycles the loader port is valid but not granted; at_max forces
//          the next contended grant to the loader port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   p1_valid     loader request valid
//   p1_grant     loader request granted this cycle
//   wait_cnt     current wait count
//   at_max       wait_cnt has reached WAIT_MAX
module starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p1_valid,
  input  logic                      p1_grant,
  output logic [WAIT_CNT_WIDTH-1:0] wait_cnt,
  output logic                      at_max
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT = WAIT_CNT_WIDTH'(WAIT_MAX);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;

  assign at_max   = (wait_cnt_q == MAX_CNT);
  assign wait_cnt = wait_cnt_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_valid || p1_grant) begin
      wait_cnt_d = '0;
    end else if (!at_max) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule : starve_counter

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port data memory
// Purpose: shares one synchronous DMEM between the CPU (port 0, fixed priority)
//          and the loader/DMA (port 1, starvation-bounded), routing read data
//          back to the issuing port one cycle after acceptance.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pN_req_valid/ready          request handshake (N = 0 CPU, 1 loader)
//   pN_req_wbe/addr/wdata       request fields; wbe == 0 means read
//   pN_rsp_valid/rdata          read response
//   mem_en/we/addr/din          memory request side
//   mem_dout                    memory read data, one cycle after a read
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WAIT_MAX   = WAIT_MAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        p0_req_valid,
  output logic                        p0_req_ready,
  input  logic [DATA_WIDTH/8-1:0]     p0_req_wbe,
  input  logic [ADDR_WIDTH-1:0]       p0_req_addr,
  input  logic [DATA_WIDTH-1:0]       p0_req_wdata,
  output logic                        p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]       p0_rsp_rdata,

  input  logic                        p1_req_valid,
  output logic                        p1_req_ready,
  input  logic [DATA_WIDTH/8-1:0]     p1_req_wbe,
  input  logic [ADDR_WIDTH-1:0]       p1_req_addr,
  input  logic [DATA_WIDTH-1:0]       p1_req_wdata,
  output logic                        p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]       p1_rsp_rdata,

  output logic                        mem_en,
  output logic [DATA_WIDTH/8-1:0]     mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_din,
  input  logic [DATA_WIDTH-1:0]       mem_dout
);

  localparam int BE_W = be_width(DATA_WIDTH);

  logic                      grant_0;
  logic                      grant_1;
  logic                      at_max;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic [1:0]                rsp_pend_d;
  logic [1:0]                rsp_pend_q;

  starve_counter #(
    .WAIT_MAX (WAIT_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .p1_valid (p1_req_valid),
    .p1_grant (grant_1),
    .wait_cnt (wait_cnt),
    .at_max   (at_max)
  );

  // Port 1 wins when it is alone or has waited WAIT_MAX cycles; port 0
  // takes whatever is left. Both are held off while reset is asserted so
  // nothing reaches the memory during reset.
  always_comb begin
    grant_1 = rst_n & p1_req_valid & (~p0_req_valid | at_max);
    grant_0 = rst_n & p0_req_valid & ~grant_1;
  end

  assign p0_req_ready = grant_0;
  assign p1_req_ready = grant_1;

  always_comb begin
    mem_en   = grant_0 | grant_1;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_1) begin
      mem_we   = p1_req_wbe;
      mem_addr = p1_req_addr;
      mem_din  = p1_req_wdata;
    end else if (grant_0) begin
      mem_we   = p0_req_wbe;
      mem_addr = p0_req_addr;
      mem_din  = p0_req_wdata;
    end
  end

  // Remember which port issued a read so next cycle's mem_dout goes back to it.
  always_comb begin
    rsp_pend_d    = '0;
    rsp_pend_d[0] = grant_0 & (p0_req_wbe == BE_W'(0));
    rsp_pend_d[1] = grant_1 & (p1_req_wbe == BE_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
    end
  end

  assign p0_rsp_valid = rsp_pend_q[PORT_CPU];
  assign p1_rsp_valid = rsp_pend_q[PORT_LOADER];
  assign p0_rsp_rdata = rsp_pend_q[PORT_CPU]    ? mem_dout : '0;
  assign p1_rsp_rdata = rsp_pend_q[PORT_LOADER] ? mem_dout : '0;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic          p0_req_ready, p1_req_ready;
  logic [BW-1:0] p0_req_wbe = '0, p1_req_wbe = '0;
  logic [AW-1:0] p0_req_addr = '0, p1_req_addr = '0;
  logic [DW-1:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic          p0_rsp_valid, p1_rsp_valid;
  logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wbe(p0_req_wbe),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wbe(p1_req_wbe),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, one-cycle read latency, byte writes.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0) begin
        mem_dout <= mem[mem_addr];
      end else begin
        for (int b = 0; b < BW; b++)
          if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] exp0 = '0, exp1 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_p0(input logic v, input logic [BW-1:0] wbe, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] e);
    p0_req_valid = v; p0_req_wbe = wbe; p0_req_addr = a; p0_req_wdata = wd; exp0 = e;
  endtask

  task automatic set_p1(input logic v, input logic [BW-1:0] wbe, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] e);
    p1_req_valid = v; p1_req_wbe = wbe; p1_req_addr = a; p1_req_wdata = wd; exp1 = e;
  endtask

  // One cycle: sample grants at negedge, record expected read responses.
  task automatic step(output logic g0, output logic g1);
    exp_t e;
    @(negedge clk);
    g0 = p0_req_ready;
    g1 = p1_req_ready;
    if (g0 && p0_req_wbe == '0) begin
      e.port = 0; e.data = exp0; e.cyc = cyc; sb.push_back(e);
    end
    if (g1 && p1_req_wbe == '0) begin
      e.port = 1; e.data = exp1; e.cyc = cyc; sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented response must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (p0_rsp_valid || p1_rsp_valid) begin
        if (p0_rsp_valid && p1_rsp_valid)
          chk("rsp_both_ports", 1, 0);
        else if (sb.size() == 0)
          chk("rsp_unexpected", {p1_rsp_valid, p0_rsp_valid}, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_port", p1_rsp_valid ? 1 : 0, e.port);
          chk("rsp_rdata", p1_rsp_valid ? p1_rsp_rdata : p0_rsp_rdata, e.data);
          chk("rsp_other_rdata_zero", p1_rsp_valid ? p0_rsp_rdata : p1_rsp_rdata, 0);
          chk("rsp_latency", cyc, e.cyc + 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic g0, g1;
  logic [9:0] cont_g1;

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", {p0_req_ready, p1_req_ready, mem_en, mem_we, p0_rsp_valid,
                          p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata}, 0);
    set_p0(1, 4'hF, 14'd1, 32'h1, 0);
    #1;
    chk("reset_no_grant", {p0_req_ready, mem_en}, 0);
    set_p0(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read, port 0
    set_p0(1, 4'hF, 14'd5, 32'hDEADBEEF, 0);
    step(g0, g1); chk("wr5_grant", {g1, g0}, 2'b01);
    set_p0(1, 4'h0, 14'd5, 0, 32'hDEADBEEF);
    step(g0, g1); chk("rd5_grant", {g1, g0}, 2'b01);
    set_p0(0, 0, 0, 0, 0);
    step(g0, g1); chk("idle_after_rd", {g1, g0}, 2'b00);

    // Byte write from port 1 over a preloaded word
    set_p0(1, 4'hF, 14'd7, 32'h11223344, 0);
    step(g0, g1); chk("wr7_grant", {g1, g0}, 2'b01);
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 4'b0010, 14'd7, 32'h0000AB00, 0);
    step(g0, g1); chk("p1_bytewr_grant", {g1, g0}, 2'b10);
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 4'h0, 14'd7, 0, 32'h1122AB44);
    step(g0, g1); chk("rd7_grant", {g1, g0}, 2'b01);

    // Contention: both reading continuously
    cont_g1 = 10'b10_0001_0000;  // bit i = port 1 granted in cycle i
    set_p0(1, 4'h0, 14'd5, 0, 32'hDEADBEEF);
    set_p1(1, 4'h0, 14'd7, 0, 32'h1122AB44);
    for (int i = 0; i < 10; i++) begin
      step(g0, g1);
      chk($sformatf("contention_c%0d", i), {g1, g0}, cont_g1[i] ? 2'b10 : 2'b01);
    end

    // Port 1 drops valid at wait_cnt = 3, then has to wait the full 4 again
    set_p1(1, 4'hF, 14'd9, 32'h0BADF00D, 0);
    for (int i = 0; i < 3; i++) begin
      step(g0, g1);
      chk($sformatf("drop_pre_c%0d", i), {g1, g0}, 2'b01);
    end
    chk("wait_cnt_3", dut.u_starve.wait_cnt, 3);
    set_p1(0, 0, 0, 0, 0);
    step(g0, g1); chk("drop_gap_grant", {g1, g0}, 2'b01);
    chk("wait_cnt_cleared", dut.u_starve.wait_cnt, 0);
    set_p1(1, 4'hF, 14'd9, 32'h0BADF00D, 0);
    for (int i = 0; i < 5; i++) begin
      step(g0, g1);
      chk($sformatf("drop_post_c%0d", i), {g1, g0}, (i == 4) ? 2'b10 : 2'b01);
    end
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 4'h0, 14'd9, 0, 32'h0BADF00D);
    step(g0, g1); chk("rd9_grant", {g1, g0}, 2'b01);
    set_p0(0, 0, 0, 0, 0);
    step(g0, g1);

    // Reset asserted with a read just accepted
    set_p0(1, 4'h0, 14'd5, 0, 32'hDEADBEEF);
    @(negedge clk);
    chk("rst_rd_accept", p0_req_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {p0_req_ready, p1_req_ready, mem_en, mem_we, p0_rsp_valid,
                             p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata}, 0);
    set_p1(1, 4'h0, 14'd7, 0, 32'h1122AB44);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_zero", {p0_req_ready, p1_req_ready, mem_en, mem_we, p0_rsp_valid,
                            p1_rsp_valid}, 0);
    end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) step(g0, g1);
    chk("post_rst_no_rsp", {p0_rsp_valid, p1_rsp_valid}, 0);
    set_p0(1, 4'h0, 14'd5, 0, 32'hDEADBEEF);
    step(g0, g1); chk("post_rst_grant", {g1, g0}, 2'b01);
    set_p0(0, 0, 0, 0, 0);

    // Idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", i), {p0_req_ready, p1_req_ready, mem_en, mem_we,
                                      dut.u_starve.wait_cnt}, 0);
    end

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dmem_arbiter
